// File: rtl/frame_seq_pkg.sv
// rtl/frame_seq_pkg.sv - shared state encoding and default geometry for the frame sequencer
package frame_seq_pkg;

    localparam int IMG_WIDTH_DEF  = 64;
    localparam int IMG_HEIGHT_DEF = 32;
    localparam int TIMEOUT_DEF    = 4096;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RUN   = 3'd1,
        ST_DRAIN = 3'd2,
        ST_DONE  = 3'd3,
        ST_ERR   = 3'd4
    } state_e;

endpackage

// File: rtl/frame_seq_if.sv
// rtl/frame_seq_if.sv - source, pipeline and sink FIFO handshake bundle
interface frame_seq_if #(
    parameter int RGB_DWIDTH = 24,
    parameter int DWIDTH     = 8
);
    logic [RGB_DWIDTH-1:0] src_din;
    logic                  src_empty;
    logic                  src_rd_en;
    logic [RGB_DWIDTH-1:0] pipe_din;
    logic                  pipe_wr_en;
    logic                  pipe_full;
    logic [DWIDTH-1:0]     pipe_dout;
    logic                  pipe_empty;
    logic                  pipe_rd_en;
    logic [DWIDTH-1:0]     sink_dout;
    logic                  sink_wr_en;
    logic                  sink_full;

    // sequencer side
    modport master (
        input  src_din, src_empty, pipe_full, pipe_dout, pipe_empty, sink_full,
        output src_rd_en, pipe_din, pipe_wr_en, pipe_rd_en, sink_dout, sink_wr_en
    );

    // FIFO / environment side
    modport slave (
        output src_din, src_empty, pipe_full, pipe_dout, pipe_empty, sink_full,
        input  src_rd_en, pipe_din, pipe_wr_en, pipe_rd_en, sink_dout, sink_wr_en
    );
endinterface

// File: rtl/frame_seq_watchdog.sv
// rtl/frame_seq_watchdog.sv - saturating stall counter that trips when it reaches TIMEOUT
module frame_seq_watchdog #(
    parameter int TIMEOUT = 4096,
    localparam int TW     = $clog2(TIMEOUT + 1)
) (
    input  logic clock,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic trip
);
    localparam logic [TW-1:0] LIMIT = TW'(TIMEOUT);

    logic [TW-1:0] count_q, count_d;

    // next count: clear wins, otherwise count up and hold at LIMIT
    always_comb begin
        count_d = count_q;
        if (clr) begin
            count_d = '0;
        end else if (en && (count_q != LIMIT)) begin
            count_d = count_q + 1'b1;
        end
        // trip on the cycle the count reaches LIMIT so the owner reacts on that same edge
        trip = (count_d == LIMIT);
    end

    // count register
    always_ff @(posedge clock) begin
        if (reset) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end
endmodule

// File: rtl/frame_sequencer.sv
// rtl/frame_sequencer.sv - frame admission/collection controller; FRAME_SEQ_PERF_EN adds frame_cycles/stall_cycles
module frame_sequencer
    import frame_seq_pkg::*;
#(
    parameter int  IMG_WIDTH  = IMG_WIDTH_DEF,
    parameter int  IMG_HEIGHT = IMG_HEIGHT_DEF,
    parameter int  RGB_DWIDTH = 24,
    parameter int  DWIDTH     = 8,
    parameter int  TIMEOUT    = TIMEOUT_DEF,
    localparam int NPIX       = IMG_WIDTH * IMG_HEIGHT,
    localparam int CW         = $clog2(NPIX + 1)
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    output logic          busy,
    output logic          done,
    output logic          error,
    frame_seq_if.master   bus,
`ifdef FRAME_SEQ_PERF_EN
    output logic [31:0]   frame_cycles,
    output logic [31:0]   stall_cycles,
`endif
    output logic [CW-1:0] in_count,
    output logic [CW-1:0] out_count
);
    localparam logic [CW-1:0] NPIX_C = CW'(NPIX);

    state_e        state_q, state_d;
    logic [CW-1:0] in_count_q, in_count_d;
    logic [CW-1:0] out_count_q, out_count_d;
    logic          error_q, error_d;

    logic busy_c;
    logic launch;
    logic in_fire;
    logic out_fire;
    logic wd_en;
    logic wd_clr;
    logic wd_trip;

    // handshake qualification; start is only honoured outside RUN/DRAIN
    always_comb begin
        busy_c   = (state_q == ST_RUN) || (state_q == ST_DRAIN);
        launch   = start && !busy_c;
        in_fire  = (state_q == ST_RUN) && !bus.src_empty && !bus.pipe_full
                   && (in_count_q < NPIX_C);
        out_fire = busy_c && !bus.pipe_empty && !bus.sink_full
                   && (out_count_q < NPIX_C);
        wd_clr   = !busy_c || out_fire;
        wd_en    = busy_c && !out_fire;
    end

    frame_seq_watchdog #(
        .TIMEOUT (TIMEOUT)
    ) u_watchdog (
        .clock (clock),
        .reset (reset),
        .clr   (wd_clr),
        .en    (wd_en),
        .trip  (wd_trip)
    );

    assign bus.src_rd_en  = in_fire;
    assign bus.pipe_wr_en = in_fire;
    assign bus.pipe_din   = bus.src_din;
    assign bus.pipe_rd_en = out_fire;
    assign bus.sink_wr_en = out_fire;
    assign bus.sink_dout  = bus.pipe_dout;

    // next state and counters; completion beats a watchdog trip in the same cycle
    always_comb begin
        state_d     = state_q;
        in_count_d  = in_count_q;
        out_count_d = out_count_q;
        error_d     = error_q;
        case (state_q)
            ST_IDLE, ST_DONE, ST_ERR: begin
                if (launch) begin
                    state_d     = ST_RUN;
                    in_count_d  = '0;
                    out_count_d = '0;
                    error_d     = 1'b0;
                end else if (state_q == ST_DONE) begin
                    state_d = ST_IDLE;
                end
            end
            ST_RUN, ST_DRAIN: begin
                if (in_fire) begin
                    in_count_d = in_count_q + 1'b1;
                end
                if (out_fire) begin
                    out_count_d = out_count_q + 1'b1;
                end
                if (out_count_d == NPIX_C) begin
                    state_d = ST_DONE;
                end else if (wd_trip) begin
                    state_d = ST_ERR;
                    error_d = 1'b1;
                end else if (in_count_d == NPIX_C) begin
                    state_d = ST_DRAIN;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // FSM and counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            state_q     <= ST_IDLE;
            in_count_q  <= '0;
            out_count_q <= '0;
            error_q     <= 1'b0;
        end else begin
            state_q     <= state_d;
            in_count_q  <= in_count_d;
            out_count_q <= out_count_d;
            error_q     <= error_d;
        end
    end

    assign busy      = busy_c;
    assign done      = (state_q == ST_DONE);
    assign error     = error_q;
    assign in_count  = in_count_q;
    assign out_count = out_count_q;

`ifdef FRAME_SEQ_PERF_EN
    logic [31:0] run_cycles_q, run_cycles_d;
    logic [31:0] frame_cycles_q, frame_cycles_d;
    logic [31:0] stall_cycles_q, stall_cycles_d;

    // frame length is the number of RUN/DRAIN cycles, latched as DONE is entered
    always_comb begin
        run_cycles_d   = run_cycles_q;
        frame_cycles_d = frame_cycles_q;
        stall_cycles_d = stall_cycles_q;
        if (launch) begin
            run_cycles_d   = '0;
            frame_cycles_d = '0;
            stall_cycles_d = '0;
        end else if (busy_c) begin
            run_cycles_d = run_cycles_q + 32'd1;
            if (state_d == ST_DONE) begin
                frame_cycles_d = run_cycles_q + 32'd1;
            end
            if ((state_q == ST_RUN) && !bus.src_empty && bus.pipe_full
                && (in_count_q < NPIX_C)) begin
                stall_cycles_d = stall_cycles_q + 32'd1;
            end
        end
    end

    // performance counter registers
    always_ff @(posedge clock) begin
        if (reset) begin
            run_cycles_q   <= '0;
            frame_cycles_q <= '0;
            stall_cycles_q <= '0;
        end else begin
            run_cycles_q   <= run_cycles_d;
            frame_cycles_q <= frame_cycles_d;
            stall_cycles_q <= stall_cycles_d;
        end
    end

    assign frame_cycles = frame_cycles_q;
    assign stall_cycles = stall_cycles_q;
`endif
endmodule

// File: tb/tb_frame_sequencer.sv
// tb/tb_frame_sequencer.sv - directed self-checking bench for frame_sequencer (4x2 frame, TIMEOUT 16)
module tb_frame_sequencer;
    localparam int NP = 8;
    localparam int TO = 16;

    logic       clk = 1'b0;
    logic       reset;
    logic       start;
    logic       busy;
    logic       done;
    logic       error;
    logic [3:0] in_count;
    logic [3:0] out_count;
`ifdef FRAME_SEQ_PERF_EN
    logic [31:0] frame_cycles;
    logic [31:0] stall_cycles;
`endif

    frame_seq_if #(.RGB_DWIDTH(24), .DWIDTH(8)) bus ();

    frame_sequencer #(
        .IMG_WIDTH  (4),
        .IMG_HEIGHT (2),
        .RGB_DWIDTH (24),
        .DWIDTH     (8),
        .TIMEOUT    (TO)
    ) dut (
        .clock        (clk),
        .reset        (reset),
        .start        (start),
        .busy         (busy),
        .done         (done),
        .error        (error),
        .bus          (bus),
`ifdef FRAME_SEQ_PERF_EN
        .frame_cycles (frame_cycles),
        .stall_cycles (stall_cycles),
`endif
        .in_count     (in_count),
        .out_count    (out_count)
    );

    always #5 clk = ~clk;

    // environment FIFO models
    logic [23:0] src_mem [32];
    logic [7:0]  pipe_mem [32];
    logic [7:0]  sink_mem [32];
    logic [5:0]  src_rd, src_wr;
    logic [5:0]  pipe_rd, pipe_wr;
    logic [5:0]  sink_n;
    logic        model_clear;
    logic        pipe_hold;
    logic        pipe_full_r;

    assign bus.src_din    = src_mem[src_rd[4:0]];
    assign bus.src_empty  = (src_rd == src_wr);
    assign bus.pipe_full  = pipe_full_r;
    assign bus.pipe_dout  = pipe_mem[pipe_rd[4:0]];
    assign bus.pipe_empty = pipe_hold || (pipe_rd == pipe_wr);
    assign bus.sink_full  = 1'b0;

    wire [3:0] en_all = {bus.src_rd_en, bus.pipe_wr_en, bus.pipe_rd_en, bus.sink_wr_en};

    // pipeline echoes the low byte of each admitted pixel as its gray value
    always @(posedge clk) begin
        if (model_clear) begin
            src_rd  <= '0;
            pipe_rd <= '0;
            pipe_wr <= '0;
            sink_n  <= '0;
        end else begin
            if (bus.src_rd_en) src_rd <= src_rd + 6'd1;
            if (bus.pipe_wr_en) begin
                pipe_mem[pipe_wr[4:0]] <= bus.pipe_din[7:0];
                pipe_wr <= pipe_wr + 6'd1;
            end
            if (bus.pipe_rd_en) pipe_rd <= pipe_rd + 6'd1;
            if (bus.sink_wr_en) begin
                sink_mem[sink_n[4:0]] <= bus.sink_dout;
                sink_n <= sink_n + 6'd1;
            end
        end
    end

    int n_total = 0;
    int n_pass  = 0;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_total++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clear_model();
        model_clear = 1'b1;
        tick();
        model_clear = 1'b0;
    endtask

    task automatic load_src(input int n, input logic [7:0] base);
        for (int i = 0; i < n; i++) begin
            src_mem[i] = {8'hA0 + 8'(i), 8'h55, base + 8'(i)};
        end
        src_wr = 6'(n);
    endtask

    task automatic check_sink(input string tag, input int n, input logic [7:0] base);
        check({tag, "_sink_n"}, 32'(sink_n), 32'(n));
        for (int i = 0; i < n; i++) begin
            check($sformatf("%s_byte%0d", tag, i), 32'(sink_mem[i]), 32'(base + 8'(i)));
        end
    endtask

    // runs until the done pulse, counting busy cycles; expiry is reported as a failed check
    task automatic wait_done(input string tag, output int busy_cyc, output logic busy_at_done);
        logic seen;
        seen = 1'b0;
        busy_cyc = 0;
        busy_at_done = 1'b1;
        for (int i = 0; i < 300 && !seen; i++) begin
            if (busy) busy_cyc++;
            tick();
            if (done) begin
                seen = 1'b1;
                busy_at_done = busy;
            end
        end
        check({tag, "_done_seen"}, 32'(seen), 32'd1);
    endtask

    int   bc;
    logic bd;
    int   bad;

    initial begin
        reset = 1'b1; start = 1'b0; model_clear = 1'b1;
        pipe_hold = 1'b0; pipe_full_r = 1'b0; src_wr = '0;
        repeat (3) tick();
        reset = 1'b0; model_clear = 1'b0;

        check("rst_busy", 32'(busy), 32'd0);
        check("rst_done", 32'(done), 32'd0);
        check("rst_error", 32'(error), 32'd0);
        check("rst_in_count", 32'(in_count), 32'd0);
        check("rst_out_count", 32'(out_count), 32'd0);
        check("rst_enables", 32'(en_all), 32'd0);

        // 1: plain 8-pixel frame, bytes 0x10..0x17
        load_src(8, 8'h10);
        start = 1'b1; tick(); start = 1'b0;
        wait_done("t1", bc, bd);
        check("t1_busy_at_done", 32'(bd), 32'd0);
        check("t1_busy_cycles", 32'(bc), 32'd9);
        check("t1_in_count", 32'(in_count), 32'd8);
        check("t1_out_count", 32'(out_count), 32'd8);
`ifdef FRAME_SEQ_PERF_EN
        check("t1_frame_cycles", frame_cycles, 32'd9);
        check("t1_stall_cycles", stall_cycles, 32'd0);
`endif
        tick();
        check("t1_done_one_cycle", 32'(done), 32'd0);
        check_sink("t1", 8, 8'h10);

        // 2: pipe_full held for 5 cycles mid-frame
        clear_model();
        load_src(8, 8'h20);
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        check("t2_in_before_stall", 32'(in_count), 32'd3);
        pipe_full_r = 1'b1;
        bad = 0;
        for (int i = 0; i < 5; i++) begin
            #1;
            if (bus.src_rd_en || bus.pipe_wr_en) bad++;
            tick();
        end
        pipe_full_r = 1'b0;
        check("t2_no_pop_in_stall", 32'(bad), 32'd0);
        check("t2_in_after_stall", 32'(in_count), 32'd3);
        wait_done("t2", bc, bd);
        check("t2_in_count", 32'(in_count), 32'd8);
`ifdef FRAME_SEQ_PERF_EN
        check("t2_stall_cycles", stall_cycles, 32'd5);
`endif
        check_sink("t2", 8, 8'h20);

        // 3: surplus source data stays in the source FIFO
        clear_model();
        load_src(10, 8'h30);
        start = 1'b1; tick(); start = 1'b0;
        wait_done("t3", bc, bd);
        repeat (3) tick();
        check("t3_popped", 32'(src_rd), 32'd8);
        check("t3_src_not_empty", 32'(bus.src_empty), 32'd0);
        check("t3_busy_cycles", 32'(bc), 32'd9);
        check_sink("t3", 8, 8'h30);

        // 4: pipeline silent -> watchdog error 16 cycles after start, then restart
        clear_model();
        load_src(8, 8'h40);
        pipe_hold = 1'b1;
        start = 1'b1; tick(); start = 1'b0;
        repeat (15) tick();
        check("t4_error_at_15", 32'(error), 32'd0);
        tick();
        check("t4_error_at_16", 32'(error), 32'd1);
        check("t4_busy_in_err", 32'(busy), 32'd0);
        check("t4_enables_in_err", 32'(en_all), 32'd0);
        repeat (3) tick();
        check("t4_error_sticky", 32'(error), 32'd1);
        pipe_hold = 1'b0;
        clear_model();
        load_src(8, 8'h50);
        start = 1'b1; tick(); start = 1'b0;
        check("t4_restart_error", 32'(error), 32'd0);
        check("t4_restart_busy", 32'(busy), 32'd1);
        wait_done("t4", bc, bd);
        check_sink("t4", 8, 8'h50);

        // 5: start held through DONE gives a back-to-back frame; start while busy ignored
        tick();
        clear_model();
        load_src(16, 8'h60);
        start = 1'b1; tick();
        wait_done("t5a", bc, bd);
        check("t5_in_at_done", 32'(in_count), 32'd8);
        tick();
        check("t5_second_busy", 32'(busy), 32'd1);
        check("t5_second_in0", 32'(in_count), 32'd0);
        check("t5_second_out0", 32'(out_count), 32'd0);
        start = 1'b0;
        wait_done("t5b", bc, bd);
        check_sink("t5", 16, 8'h60);

        // 6: reset mid-frame aborts without a done pulse
        tick();
        clear_model();
        load_src(8, 8'h70);
        start = 1'b1; tick(); start = 1'b0;
        repeat (3) tick();
        check("t6_in_before_rst", 32'(in_count), 32'd3);
        reset = 1'b1; tick();
        check("t6_busy", 32'(busy), 32'd0);
        check("t6_in_count", 32'(in_count), 32'd0);
        check("t6_out_count", 32'(out_count), 32'd0);
        check("t6_done", 32'(done), 32'd0);
        check("t6_enables", 32'(en_all), 32'd0);
        reset = 1'b0;
        bad = 0;
        for (int i = 0; i < 4; i++) begin
            tick();
            if (done || busy) bad++;
        end
        check("t6_quiet_after_rst", 32'(bad), 32'd0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
